fwd_regfile_pipe: RTL and testbench
===================================

// Module: fwd_regfile_pipe
// PURPOSE
// - Decode-stage register file plus operand forwarding network for the pipelined Y86-64 core; generalises the single-operand forward select.
// - Provides NPORTS read ports, each with the same forwarding priority, and guards the RNONE id so it never forwards.
// - Owns the architectural registers: write-back from W, with a same-cycle write-to-read bypass.
// - Detects load/use hazards and counts stall cycles with a saturating counter.
// PARAMETERS
// - WIDTH    64     data width of registers and forwarded values
// - RW       4      register-id width
// - NREG     15     architectural registers, ids 0..NREG-1
// - NPORTS   2      decode read ports (srcA, srcB, ...)
// - RNONE    4'hF   "no register" id; never read, written or matched
// - RSP_ID   4      stack-pointer id
// - RSP_INIT 0      reset value of register RSP_ID
// - CNTW     32     stall-counter width
// PORTS
// - clk          in   1              rising-edge clock
// - rst          in   1              synchronous, active-high reset
// - d_src        in   NPORTS*RW      source ids; port p = bits [p*RW +: RW]
// - d_val        out  NPORTS*WIDTH   forwarded operand for each port
// - e_dstE       in   RW             execute-stage ALU destination
// - e_valE       in   WIDTH          execute-stage ALU result
// - E_dstM       in   RW             load destination of the instruction now in execute
// - M_dstE       in   RW             memory-stage ALU destination
// - M_valE       in   WIDTH          memory-stage ALU value
// - M_dstM       in   RW             memory-stage load destination
// - m_valM       in   WIDTH          memory read data
// - W_dstE       in   RW             write-back ALU destination
// - W_valE       in   WIDTH          write-back ALU value
// - W_dstM       in   RW             write-back load destination
// - W_valM       in   WIDTH          write-back load value
// - d_stall      out  1              load/use hazard; decode must hold and E takes a bubble
// - stall_count  out  CNTW           cycles with d_stall=1 since reset, saturating
// BEHAVIOUR
// - Reset:
//   - On rising clk with rst=1: all registers clear to 0, except reg[RSP_ID], which loads RSP_INIT.
//   - stall_count clears to 0.
//   - d_val and d_stall are combinational, so they follow the reset register state in the next cycle.
// - Forwarding, per port, combinational, zero latency:
//   - If src==RNONE or src>=NREG, then d_val=0.
//   - Otherwise the first match in this order wins: e_dstE->e_valE, M_dstM->m_valM, M_dstE->M_valE, W_dstM->W_valM, W_dstE->W_valE, else reg[src].
//   - A destination equal to RNONE never matches.
// - Write-back, at the clock edge, when rst=0:
//   - reg[W_dstE]<=W_valE and reg[W_dstM]<=W_valM.
//   - If W_dstE==W_dstM (not RNONE), W_valM wins.
//   - Ids equal to RNONE or >=NREG are ignored.
// - The W_* forwarding terms make a read in the write cycle return the new value, so there is no read-after-write gap.
// - Hazard:
//   - d_stall=1 when E_dstM!=RNONE and E_dstM equals any port's d_src.
//   - The block never stalls on an ALU-only dependency.
// - Counter:
//   - stall_count increments when d_stall=1 and rst=0.
//   - It holds at 2^CNTW-1; there is no wrap.
// - Reset mid-operation:
//   - Any write-back in the same cycle as rst=1 is dropped.
//   - The counter reset takes priority over an increment.
// STRUCTURE
// - Shared package holds: RNONE, RSP_ID, the register-id typedef (logic [RW-1:0]), and the forward-priority encoding enum (FWD_E_E, FWD_M_M, FWD_M_E, FWD_W_M, FWD_W_E, FWD_RF).
// - Sub-module fwd_sel_port: one combinational priority mux per read port, instantiated NPORTS times in a generate loop.
// - The register array, write-back logic, hazard OR-reduction and counter stay in the top level.
// TESTING
// - Reset with RSP_INIT=64'h100: read src=RSP_ID gives 64'h100; read src=3 gives 0; stall_count=0.
// - Priority: all five dsts = 2 with distinct vals (e=1, m=2, M_E=3, W_M=4, W_E=5); read src=2 gives 1. Set e_dstE=F: gives 2. Continue removing sources down to the register value.
// - RNONE guard: every dst=F and src=F gives d_val=0 and d_stall=0. Reg 15 is never written even when W_dstE=F.
// - Write-back collision: W_dstE=W_dstM=6, W_valE=7, W_valM=9. Next cycle, with no forwarding sources active, src=6 gives 9. In the write cycle itself, src=6 also gives 9.
// - Load/use: E_dstM=5 with port1 src=5 gives d_stall=1; hold this for 3 cycles and stall_count=3. Set E_dstM=F: d_stall=0.
// - Saturation and reset: with CNTW=4, hold a stall for 20 cycles and stall_count=15. Assert rst while W_dstE=2 and d_stall=1: reg2=0 and the count is 0 afterward.

Source files
------------

// File: rtl/fwd_regfile_pipe_pkg.sv
// Shared definitions for the decode-stage register file and forwarding network.
// Contents: register-id width and typedef, the "no register" id, the
// stack-pointer id, and the encoding that names which pipeline source
// supplies a forwarded operand.
package fwd_regfile_pipe_pkg;

  localparam int unsigned REG_ID_W = 4;

  typedef logic [REG_ID_W-1:0] reg_id_t;

  localparam reg_id_t REG_NONE = 4'hF;
  localparam reg_id_t REG_RSP  = 4'h4;

  // Forwarding sources in priority order, highest first.
  typedef enum logic [2:0] {
    FWD_E_E = 3'd0,  // execute ALU result
    FWD_M_M = 3'd1,  // memory read data
    FWD_M_E = 3'd2,  // memory-stage ALU value
    FWD_W_M = 3'd3,  // write-back load value
    FWD_W_E = 3'd4,  // write-back ALU value
    FWD_RF  = 3'd5   // architectural register file
  } fwd_sel_e;

endpackage

// File: rtl/fwd_regfile_pipe_fwd_sel_port.sv
// One decode read port: combinational priority mux that picks the youngest
// in-flight producer of the requested register, falling back to the
// register-file value.
// Ports:
//   src            requested register id
//   e_dstE/e_valE  execute ALU destination / result
//   M_dstM/m_valM  memory load destination / read data
//   M_dstE/M_valE  memory-stage ALU destination / value
//   W_dstM/W_valM  write-back load destination / value
//   W_dstE/W_valE  write-back ALU destination / value
//   rf_val         register-file contents for src
//   val            forwarded operand (0 for RNONE or out-of-range ids)
module fwd_sel_port
  import fwd_regfile_pipe_pkg::*;
#(
  parameter int unsigned       WIDTH = 64,
  parameter int unsigned       RW    = 4,
  parameter int unsigned       NREG  = 15,
  parameter logic [RW-1:0]     RNONE = 4'hF
) (
  input  logic [RW-1:0]    src,
  input  logic [RW-1:0]    e_dstE,
  input  logic [WIDTH-1:0] e_valE,
  input  logic [RW-1:0]    M_dstM,
  input  logic [WIDTH-1:0] m_valM,
  input  logic [RW-1:0]    M_dstE,
  input  logic [WIDTH-1:0] M_valE,
  input  logic [RW-1:0]    W_dstM,
  input  logic [WIDTH-1:0] W_valM,
  input  logic [RW-1:0]    W_dstE,
  input  logic [WIDTH-1:0] W_valE,
  input  logic [WIDTH-1:0] rf_val,
  output logic [WIDTH-1:0] val
);

  fwd_sel_e sel_s;
  logic     src_ok_s;

  // A destination of RNONE marks "no write" and must never match a reader.
  function automatic logic dst_hit(input logic [RW-1:0] dst, input logic [RW-1:0] rd);
    return (dst != RNONE) && (dst == rd);
  endfunction

  // Pick the highest-priority source that targets this port's register.
  always_comb begin
    src_ok_s = (src != RNONE) && (32'(src) < NREG);
    if (dst_hit(e_dstE, src)) begin
      sel_s = FWD_E_E;
    end else if (dst_hit(M_dstM, src)) begin
      sel_s = FWD_M_M;
    end else if (dst_hit(M_dstE, src)) begin
      sel_s = FWD_M_E;
    end else if (dst_hit(W_dstM, src)) begin
      sel_s = FWD_W_M;
    end else if (dst_hit(W_dstE, src)) begin
      sel_s = FWD_W_E;
    end else begin
      sel_s = FWD_RF;
    end
  end

  // Steer the selected value; invalid ids always read as zero.
  always_comb begin
    val = {WIDTH{1'b0}};
    if (src_ok_s) begin
      case (sel_s)
        FWD_E_E: val = e_valE;
        FWD_M_M: val = m_valM;
        FWD_M_E: val = M_valE;
        FWD_W_M: val = W_valM;
        FWD_W_E: val = W_valE;
        FWD_RF:  val = rf_val;
        default: val = {WIDTH{1'b0}};
      endcase
    end else begin
      val = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/fwd_regfile_pipe.sv
// Decode-stage register file with operand forwarding and load/use detection.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   d_src          NPORTS packed source ids (port p at [p*RW +: RW])
//   d_val          NPORTS packed forwarded operands
//   e_dstE/e_valE  execute ALU destination / result
//   E_dstM         load destination of the instruction in execute
//   M_dstE/M_valE  memory-stage ALU destination / value
//   M_dstM/m_valM  memory-stage load destination / read data
//   W_dstE/W_valE  write-back ALU destination / value (also written to regs)
//   W_dstM/W_valM  write-back load destination / value (also written to regs)
//   d_stall        load/use hazard on any read port
//   stall_count    saturating count of stalled cycles since reset
module fwd_regfile_pipe
  import fwd_regfile_pipe_pkg::*;
#(
  parameter int unsigned   WIDTH    = 64,
  parameter int unsigned   RW       = REG_ID_W,
  parameter int unsigned   NREG     = 15,
  parameter int unsigned   NPORTS   = 2,
  parameter logic [RW-1:0] RNONE    = REG_NONE,
  parameter logic [RW-1:0] RSP_ID   = REG_RSP,
  parameter logic [WIDTH-1:0] RSP_INIT = {WIDTH{1'b0}},
  parameter int unsigned   CNTW     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NPORTS*RW-1:0]    d_src,
  output logic [NPORTS*WIDTH-1:0] d_val,
  input  logic [RW-1:0]           e_dstE,
  input  logic [WIDTH-1:0]        e_valE,
  input  logic [RW-1:0]           E_dstM,
  input  logic [RW-1:0]           M_dstE,
  input  logic [WIDTH-1:0]        M_valE,
  input  logic [RW-1:0]           M_dstM,
  input  logic [WIDTH-1:0]        m_valM,
  input  logic [RW-1:0]           W_dstE,
  input  logic [WIDTH-1:0]        W_valE,
  input  logic [RW-1:0]           W_dstM,
  input  logic [WIDTH-1:0]        W_valM,
  output logic                    d_stall,
  output logic [CNTW-1:0]         stall_count
);

  logic [WIDTH-1:0] reg_q [NREG];
  logic [WIDTH-1:0] reg_d [NREG];
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;

  // Next register state: W_dstM is applied last so it wins a collision.
  // Ids >= NREG (including RNONE) never match a loop index.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      if ((W_dstM != RNONE) && (W_dstM == RW'(r))) begin
        reg_d[r] = W_valM;
      end else if ((W_dstE != RNONE) && (W_dstE == RW'(r))) begin
        reg_d[r] = W_valE;
      end else begin
        reg_d[r] = reg_q[r];
      end
    end
  end

  // Register file state; reset drops any same-cycle write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        reg_q[r] <= (RW'(r) == RSP_ID) ? RSP_INIT : {WIDTH{1'b0}};
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        reg_q[r] <= reg_d[r];
      end
    end
  end

  // Read ports: each gets its own register-file mux feeding a forward selector.
  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [RW-1:0]    src_s;
    logic [WIDTH-1:0] rf_rd_s;

    assign src_s = d_src[p*RW +: RW];

    // Register-file read; out-of-range ids read zero and are masked anyway.
    always_comb begin
      rf_rd_s = {WIDTH{1'b0}};
      for (int r = 0; r < NREG; r++) begin
        if (src_s == RW'(r)) begin
          rf_rd_s = reg_q[r];
        end else begin
          rf_rd_s = rf_rd_s;
        end
      end
    end

    fwd_sel_port #(
      .WIDTH (WIDTH),
      .RW    (RW),
      .NREG  (NREG),
      .RNONE (RNONE)
    ) u_sel (
      .src    (src_s),
      .e_dstE (e_dstE),
      .e_valE (e_valE),
      .M_dstM (M_dstM),
      .m_valM (m_valM),
      .M_dstE (M_dstE),
      .M_valE (M_valE),
      .W_dstM (W_dstM),
      .W_valM (W_valM),
      .W_dstE (W_dstE),
      .W_valE (W_valE),
      .rf_val (rf_rd_s),
      .val    (d_val[p*WIDTH +: WIDTH])
    );
  end

  // Load/use hazard: a pending load into any register a port is reading.
  // ALU-only producers are covered by forwarding and never stall.
  always_comb begin
    d_stall = 1'b0;
    if (E_dstM != RNONE) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (d_src[p*RW +: RW] == E_dstM) begin
          d_stall = 1'b1;
        end else begin
          d_stall = d_stall;
        end
      end
    end else begin
      d_stall = 1'b0;
    end
  end

  // Saturating stall counter next state.
  always_comb begin
    if (d_stall && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall counter state; reset overrides an increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNTW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_regfile_pipe.sv
module tb_fwd_regfile_pipe;

  localparam int NP = 2;
  localparam int NR = 15;
  localparam logic [63:0] RSPV = 64'h100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    d_src;
  logic [127:0]  d_val;
  logic [3:0]    e_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0]   e_valE, M_valE, m_valM, W_valE, W_valM;
  logic          d_stall;
  logic [3:0]    stall_count;

  always #5 clk = ~clk;

  fwd_regfile_pipe #(.RSP_INIT(RSPV), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .d_src(d_src), .d_val(d_val),
    .e_dstE(e_dstE), .e_valE(e_valE), .E_dstM(E_dstM),
    .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_stall(d_stall), .stall_count(stall_count)
  );

  typedef struct {
    bit          chk;
    logic [63:0] val [NP];
    logic        stall;
    logic [3:0]  cnt;
  } exp_t;

  exp_t        exp_q [$];
  logic [63:0] m_regs [NR];
  int          m_cnt;
  int          errors = 0;
  int          checks = 0;

  // Reference read: scan producers youngest-first, else the register array.
  function automatic logic [63:0] m_read(input logic [3:0] src);
    logic [3:0]  dsts [5];
    logic [63:0] vals [5];
    dsts = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (int'(src) >= NR) return 64'd0;
    for (int k = 0; k < 5; k++)
      if (dsts[k] != 4'hF && dsts[k] == src) return vals[k];
    return m_regs[int'(src)];
  endfunction

  // One clock: apply rst, record expected outputs, advance the model.
  task automatic cycle(input logic rst_i, input bit chk_i);
    exp_t e;
    logic any;
    rst = rst_i;
    e.chk = chk_i;
    any = 1'b0;
    for (int p = 0; p < NP; p++) begin
      e.val[p] = m_read(d_src[p*4 +: 4]);
      if (E_dstM != 4'hF && d_src[p*4 +: 4] == E_dstM) any = 1'b1;
    end
    e.stall = any;
    e.cnt = 4'(m_cnt);
    exp_q.push_back(e);
    if (rst_i) begin
      for (int r = 0; r < NR; r++) m_regs[r] = 64'd0;
      m_regs[4] = RSPV;
      m_cnt = 0;
    end else begin
      if (int'(W_dstE) < NR) m_regs[int'(W_dstE)] = W_valE;
      if (int'(W_dstM) < NR) m_regs[int'(W_dstM)] = W_valM;
      if (any && m_cnt < 15) m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_src = 8'hFF;
    e_dstE = 4'hF; E_dstM = 4'hF; M_dstE = 4'hF;
    M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0;
    W_valE = 64'd0; W_valM = 64'd0;
  endtask

  function automatic logic [3:0] rid();
    if ($urandom_range(0, 3) == 0) return 4'hF;
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [63:0] rval();
    return {$urandom, $urandom};
  endfunction

  // Monitor: each settled cycle, pop the expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          for (int p = 0; p < NP; p++) begin
            checks++;
            if (d_val[p*64 +: 64] !== e.val[p]) begin
              errors++;
              $display("FAIL d_val[%0d] src=%h got=%h want=%h at %0t",
                       p, d_src[p*4 +: 4], d_val[p*64 +: 64], e.val[p], $time);
            end
          end
          checks++;
          if (d_stall !== e.stall) begin
            errors++;
            $display("FAIL d_stall got=%b want=%b at %0t", d_stall, e.stall, $time);
          end
          checks++;
          if (stall_count !== e.cnt) begin
            errors++;
            $display("FAIL stall_count got=%0d want=%0d at %0t", stall_count, e.cnt, $time);
          end
        end
      end
    end
  end

  initial begin
    int waited;
    m_cnt = 0;
    for (int r = 0; r < NR; r++) m_regs[r] = 64'd0;
    idle();
    @(posedge clk);
    #1;
    // Reset: DUT state is unknown before the first reset edge.
    cycle(1'b1, 1'b0);
    d_src = {4'd3, 4'd4};
    cycle(1'b0, 1'b1);

    // Forwarding priority, removing sources one at a time.
    idle();
    d_src = {4'hF, 4'd2};
    e_dstE = 4'd2; M_dstM = 4'd2; M_dstE = 4'd2; W_dstM = 4'd2; W_dstE = 4'd2;
    e_valE = 64'd1; m_valM = 64'd2; M_valE = 64'd3; W_valM = 64'd4; W_valE = 64'd5;
    cycle(1'b0, 1'b1);
    e_dstE = 4'hF; cycle(1'b0, 1'b1);
    M_dstM = 4'hF; cycle(1'b0, 1'b1);
    M_dstE = 4'hF; cycle(1'b0, 1'b1);
    W_dstM = 4'hF; cycle(1'b0, 1'b1);
    W_dstE = 4'hF; cycle(1'b0, 1'b1);

    // RNONE guard: W_dstE=F with a live value must not land anywhere.
    idle();
    W_valE = 64'hDEAD_BEEF; W_valM = 64'h1234;
    cycle(1'b0, 1'b1);
    d_src = {4'd2, 4'd4};
    cycle(1'b0, 1'b1);

    // Write-back collision: load value wins, both in and after the write cycle.
    idle();
    W_dstE = 4'd6; W_dstM = 4'd6; W_valE = 64'd7; W_valM = 64'd9;
    d_src = {4'hF, 4'd6};
    cycle(1'b0, 1'b1);
    idle();
    d_src = {4'hF, 4'd6};
    cycle(1'b0, 1'b1);

    // Load/use on port 1 for three cycles, then released.
    idle();
    E_dstM = 4'd5; d_src = {4'd5, 4'd1};
    repeat (3) cycle(1'b0, 1'b1);
    E_dstM = 4'hF;
    cycle(1'b0, 1'b1);

    // Saturation at 2^4-1.
    E_dstM = 4'd5;
    repeat (20) cycle(1'b0, 1'b1);

    // Reset while writing and stalling: write dropped, counter cleared.
    W_dstE = 4'd2; W_valE = 64'h55;
    cycle(1'b1, 1'b1);
    idle();
    d_src = {4'd4, 4'd2};
    cycle(1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      d_src = {rid(), rid()};
      e_dstE = rid(); E_dstM = rid(); M_dstE = rid();
      M_dstM = rid(); W_dstE = rid(); W_dstM = rid();
      e_valE = rval(); M_valE = rval(); m_valM = rval();
      W_valE = rval(); W_valM = rval();
      cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, 1'b1);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 5) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
